// File: rtl/vga_frame_reader.sv
// vga_frame_reader: display-side reader for the filtered-image VGA path.
// Generates VGA timing once VGA_EN is seen and fetches pixels from two
// synchronous image RAMs. Each output is registered through a three-stage
// pipeline: decode -> address -> RAM data -> pixel/sync outputs.
//
// Build macro VGA_SIDE_BY_SIDE_EN:
//   defined   - noisy image (VGA_DATA_N) in the left half, filtered image
//               (VGA_DATA) in the right half, each centred in its half.
//   undefined - single centred window of the filtered image; VGA_DATA_N ignored.
module vga_frame_reader #(
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned A_WIDTH  = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               VGA_EN,
    input  logic [D_WIDTH-1:0] VGA_DATA,
    input  logic [D_WIDTH-1:0] VGA_DATA_N,
    output logic [A_WIDTH-1:0] VGA_ADDR,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               BLANK_N,
    output logic [D_WIDTH-1:0] PIXEL,
    output logic               FRAME_START
);

    // Image geometry: square image, address = {row, col}
    localparam int unsigned SW      = A_WIDTH / 2;
    localparam int unsigned SIDE    = 1 << SW;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Image rows are centred vertically in the active area
    localparam logic [9:0] Y_BEG  = 10'((V_ACTIVE - SIDE) / 2);
    localparam logic [9:0] Y_END  = 10'((V_ACTIVE - SIDE) / 2 + SIDE);

`ifdef VGA_SIDE_BY_SIDE_EN
    // Each image centred in its own half of the line
    localparam logic [9:0] XN_BEG = 10'((H_ACTIVE / 2 - SIDE) / 2);
    localparam logic [9:0] XN_END = 10'((H_ACTIVE / 2 - SIDE) / 2 + SIDE);
    localparam logic [9:0] XF_BEG = 10'(H_ACTIVE / 2 + (H_ACTIVE / 2 - SIDE) / 2);
    localparam logic [9:0] XF_END = 10'(H_ACTIVE / 2 + (H_ACTIVE / 2 - SIDE) / 2 + SIDE);
    localparam int unsigned SEL_W = 2;
`else
    localparam logic [9:0] XF_BEG = 10'((H_ACTIVE - SIDE) / 2);
    localparam logic [9:0] XF_END = 10'((H_ACTIVE - SIDE) / 2 + SIDE);
    localparam int unsigned SEL_W = 1;
`endif

    // Select bits: [0] filtered window, [1] noisy window (side-by-side only)
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             state_q, state_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;

    // Stage 0 (decode of the current counter position)
    logic             run;
    logic             in_rows;
    logic [SW-1:0]    row;
    logic [SW-1:0]    col_f;
    logic [SEL_W-1:0] sel0;
    logic [A_WIDTH-1:0] addr0;
    logic             hs0, vs0, bl0, fs0;

    // Stage 1 and 2 delay registers
    logic [SEL_W-1:0] sel1_q, sel2_q;
    logic             hs1_q, vs1_q, bl1_q, fs1_q;
    logic             hs2_q, vs2_q, bl2_q, fs2_q;

    logic [D_WIDTH-1:0] pix_d;

`ifdef VGA_SIDE_BY_SIDE_EN
    logic [SW-1:0]    col_n;
`else
    logic             unused_data_n;
    assign unused_data_n = ^VGA_DATA_N;
`endif

    // Next-state for the run/idle control and the raster counters
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        if (state_q == ST_IDLE) begin
            h_d = '0;
            v_d = '0;
            if (VGA_EN) begin
                state_d = ST_RUN;
            end
        end else begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                    // Enable is only honoured at the frame boundary
                    if (!VGA_EN) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Control state and raster counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
        end
    end

    // Window, sync and blank decode for the current position
    always_comb begin
        run     = (state_q == ST_RUN);
        in_rows = (v_q >= Y_BEG) && (v_q < Y_END);
        // Low bits of the difference equal the difference of the low bits
        row     = v_q[SW-1:0] - Y_BEG[SW-1:0];
        col_f   = h_q[SW-1:0] - XF_BEG[SW-1:0];
`ifdef VGA_SIDE_BY_SIDE_EN
        col_n   = h_q[SW-1:0] - XN_BEG[SW-1:0];
`endif
        sel0    = '0;
        addr0   = '0;
        hs0     = 1'b1;
        vs0     = 1'b1;
        bl0     = 1'b0;
        fs0     = 1'b0;
        if (run) begin
            hs0 = !((h_q >= HS_BEG) && (h_q < HS_END));
            vs0 = !((v_q >= VS_BEG) && (v_q < VS_END));
            bl0 = (h_q < H_ACT) && (v_q < V_ACT);
            fs0 = (h_q == '0) && (v_q == '0);
            if (in_rows && (h_q >= XF_BEG) && (h_q < XF_END)) begin
                sel0[0] = 1'b1;
                addr0   = {row, col_f};
            end
`ifdef VGA_SIDE_BY_SIDE_EN
            if (in_rows && (h_q >= XN_BEG) && (h_q < XN_END)) begin
                sel0[1] = 1'b1;
                addr0   = {row, col_n};
            end
`endif
        end
    end

    // Stage 1: registered RAM address plus delayed select and timing flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            VGA_ADDR <= '0;
            sel1_q   <= '0;
            hs1_q    <= 1'b1;
            vs1_q    <= 1'b1;
            bl1_q    <= 1'b0;
            fs1_q    <= 1'b0;
        end else begin
            VGA_ADDR <= addr0;
            sel1_q   <= sel0;
            hs1_q    <= hs0;
            vs1_q    <= vs0;
            bl1_q    <= bl0;
            fs1_q    <= fs0;
        end
    end

    // Stage 2: flags wait here while the RAM returns data for this position
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sel2_q <= '0;
            hs2_q  <= 1'b1;
            vs2_q  <= 1'b1;
            bl2_q  <= 1'b0;
            fs2_q  <= 1'b0;
        end else begin
            sel2_q <= sel1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            bl2_q  <= bl1_q;
            fs2_q  <= fs1_q;
        end
    end

    // Pixel source select, aligned with RAM data
    always_comb begin
        pix_d = '0;
`ifdef VGA_SIDE_BY_SIDE_EN
        if (sel2_q[1]) begin
            pix_d = VGA_DATA_N;
        end else if (sel2_q[0]) begin
            pix_d = VGA_DATA;
        end
`else
        if (sel2_q[0]) begin
            pix_d = VGA_DATA;
        end
`endif
    end

    // Stage 3: all DAC-side outputs registered together
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            PIXEL       <= '0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            BLANK_N     <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            PIXEL       <= pix_d;
            HSYNC       <= hs2_q;
            VSYNC       <= vs2_q;
            BLANK_N     <= bl2_q;
            FRAME_START <= fs2_q;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Self-checking bench for vga_frame_reader using a reduced raster
// (100x50 total, 16x16 images) so several whole frames fit in a short run.
// A behavioural model predicts the output stream per cycle into a queue;
// a separate monitor pops and compares at the pipeline latency.
module tb_vga_frame_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned HA = 80;
    localparam int unsigned HF = 4;
    localparam int unsigned HS = 8;
    localparam int unsigned HB = 8;
    localparam int unsigned VA = 40;
    localparam int unsigned VF = 2;
    localparam int unsigned VS = 2;
    localparam int unsigned VB = 6;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned SIDE = 1 << (AW / 2);
    localparam int unsigned Y0 = (VA - SIDE) / 2;
`ifdef VGA_SIDE_BY_SIDE_EN
    localparam int unsigned XN = (HA / 2 - SIDE) / 2;
    localparam int unsigned XF = HA / 2 + XN;
`else
    localparam int unsigned XF = (HA - SIDE) / 2;
`endif

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          bl;
        logic          fs;
        logic [DW-1:0] pix;
    } exp_t;

    logic          CLK;
    logic          nRST;
    logic          VGA_EN;
    logic [DW-1:0] VGA_DATA;
    logic [DW-1:0] VGA_DATA_N;
    logic [AW-1:0] VGA_ADDR;
    logic          HSYNC;
    logic          VSYNC;
    logic          BLANK_N;
    logic [DW-1:0] PIXEL;
    logic          FRAME_START;

    logic [DW-1:0] mem_f [0:(1<<AW)-1];
    logic [DW-1:0] mem_n [0:(1<<AW)-1];

    exp_t          exp_q [$];
    logic [AW-1:0] addr_q [$];

    int            n_checks;
    int            n_pass;
    bit            m_run;
    int unsigned   m_p;

    vga_frame_reader #(
        .D_WIDTH  (DW),
        .A_WIDTH  (AW),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .VGA_EN      (VGA_EN),
        .VGA_DATA    (VGA_DATA),
        .VGA_DATA_N  (VGA_DATA_N),
        .VGA_ADDR    (VGA_ADDR),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .BLANK_N     (BLANK_N),
        .PIXEL       (PIXEL),
        .FRAME_START (FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous image RAMs with one-cycle read latency
    always @(posedge CLK) begin
        VGA_DATA   <= mem_f[VGA_ADDR];
        VGA_DATA_N <= mem_n[VGA_ADDR];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    endtask

    // Expected outputs and address for one screen position
    function automatic void predict(input bit on, input int unsigned h, input int unsigned v,
                                    output exp_t e, output logic [AW-1:0] a);
        int unsigned row;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
        e.bl  = 1'b0;
        e.fs  = 1'b0;
        e.pix = '0;
        a     = '0;
        if (on) begin
            e.hs = !(h >= HA + HF && h < HA + HF + HS);
            e.vs = !(v >= VA + VF && v < VA + VF + VS);
            e.bl = (h < HA) && (v < VA);
            e.fs = (h == 0) && (v == 0);
            if (v >= Y0 && v < Y0 + SIDE) begin
                row = v - Y0;
                if (h >= XF && h < XF + SIDE) begin
                    a     = AW'(row * SIDE + (h - XF));
                    e.pix = mem_f[a];
                end
`ifdef VGA_SIDE_BY_SIDE_EN
                if (h >= XN && h < XN + SIDE) begin
                    a     = AW'(row * SIDE + (h - XN));
                    e.pix = mem_n[a];
                end
`endif
            end
        end
    endfunction

    task automatic check_idle_now(input string tag);
        check({tag, "_hsync"}, 32'(HSYNC), 32'd1);
        check({tag, "_vsync"}, 32'(VSYNC), 32'd1);
        check({tag, "_blank_n"}, 32'(BLANK_N), 32'd0);
        check({tag, "_pixel"}, 32'(PIXEL), 32'd0);
        check({tag, "_addr"}, 32'(VGA_ADDR), 32'd0);
        check({tag, "_frame_start"}, 32'(FRAME_START), 32'd0);
    endtask

    initial begin
        int idle_bad, fs_seen, hs_low, vs_low, lat;
        n_checks = 0;
        n_pass   = 0;
        m_run    = 1'b0;
        m_p      = 0;
        nRST     = 1'b0;
        VGA_EN   = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            mem_f[i] = DW'($urandom_range(255));
            mem_n[i] = DW'($urandom_range(255));
        end

        fork
            // Reference model: advance one screen position per clock
            begin
                exp_t          e;
                logic [AW-1:0] a;
                forever begin
                    @(posedge CLK);
                    #1;
                    if (!nRST) begin
                        m_run = 1'b0;
                        m_p   = 0;
                    end else if (!m_run) begin
                        if (VGA_EN) begin
                            m_run = 1'b1;
                            m_p   = 0;
                        end
                    end else if (m_p == FRAME - 1) begin
                        m_p = 0;
                        if (!VGA_EN) m_run = 1'b0;
                    end else begin
                        m_p++;
                    end
                    predict(m_run, m_p % HT, m_p / HT, e, a);
                    exp_q.push_back(e);
                    addr_q.push_back(a);
                end
            end
            // Monitor: address one cycle after decode, outputs three after
            begin
                exp_t          e;
                logic [AW-1:0] a;
                forever begin
                    @(negedge CLK);
                    if (addr_q.size() > 1) begin
                        a = addr_q.pop_front();
                        check("vga_addr", 32'(VGA_ADDR), 32'(a));
                    end
                    if (exp_q.size() > 3) begin
                        e = exp_q.pop_front();
                        check("hs_vs_blank_fs_pixel",
                              32'({HSYNC, VSYNC, BLANK_N, FRAME_START, PIXEL}), 32'(e));
                    end
                end
            end
        join_none

        // Reset held with enable high
        repeat (5) @(negedge CLK);
        check_idle_now("reset");

        // Idle hold with enable low
        nRST     = 1'b1;
        VGA_EN   = 1'b0;
        idle_bad = 0;
        fs_seen  = 0;
        repeat (2000) begin
            @(negedge CLK);
            if (FRAME_START) fs_seen++;
            if (!(HSYNC && VSYNC && !BLANK_N && PIXEL == 0 && VGA_ADDR == 0)) idle_bad++;
        end
        check("idle_frame_start_pulses", 32'(fs_seen), 32'd0);
        check("idle_nonidle_cycles", 32'(idle_bad), 32'd0);

        // First FRAME_START latency: seen after the 4th rising edge counting the sampling edge
        VGA_EN = 1'b1;
        lat    = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if (FRAME_START && lat == 0) lat = i;
            if (lat != 0) break;
        end
        check("first_frame_start_latency", 32'(lat), 32'd4);

        // One whole frame starting at the FRAME_START cycle
        hs_low  = 0;
        vs_low  = 0;
        fs_seen = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!HSYNC) hs_low++;
            if (!VSYNC) vs_low++;
            if (FRAME_START) fs_seen++;
            @(negedge CLK);
        end
        check("hsync_low_per_frame", 32'(hs_low), 32'(HS * VT));
        check("vsync_low_per_frame", 32'(vs_low), 32'(VS * HT));
        check("frame_start_per_frame", 32'(fs_seen), 32'd1);

        // Random enable drops: frame completes, then pipeline drains to idle
        for (int it = 0; it < 3; it++) begin
            repeat ($urandom_range(FRAME - 1, 1)) @(negedge CLK);
            VGA_EN = 1'b0;
            repeat (FRAME + 8) @(negedge CLK);
            check("drop_idle_flags", 32'({HSYNC, VSYNC, BLANK_N, FRAME_START}), 32'b1100);
            repeat ($urandom_range(40, 1)) @(negedge CLK);
            VGA_EN = 1'b1;
        end

        // Asynchronous reset in the middle of a line
        repeat ($urandom_range(FRAME - 1, HT)) @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check_idle_now("async_reset");
        exp_q.delete();
        addr_q.delete();
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (FRAME + 20) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
